uart_cerceve_yukleyici: RTL and testbench
=========================================

UART_CERCEVE_YUKLEYICI -- requirements
Module: uart_cerceve_yukleyici

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 76800, meaning bytes per frame (must be at least 1).
REQ-002 The block SHALL have parameter ADDR_W, default 17, meaning RAM address width.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 100_000_000, meaning the maximum idle clocks allowed in REQ before an error.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port start_i, input, 1 bit: begin a frame load; sampled only in IDLE.
REQ-008 The block SHALL have port abort_i, input, 1 bit: cancel the load in progress.
REQ-009 The block SHALL have port fifo_empty_i, input, 1 bit: UART RX FIFO empty flag.
REQ-010 The block SHALL have port fifo_rdata_i, input, 8 bits: FIFO read data, valid the cycle after a pop.
REQ-011 The block SHALL have port fifo_rd_en_o, output, 1 bit: FIFO pop strobe.
REQ-012 The block SHALL have port ram_en_o, output, 1 bit: RAM enable.
REQ-013 The block SHALL have port ram_we_o, output, 1 bit: RAM write enable.
REQ-014 The block SHALL have port ram_addr_o, output, ADDR_W bits: RAM write address.
REQ-015 The block SHALL have port ram_data_o, output, 8 bits: RAM write data.
REQ-016 The block SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-017 The block SHALL have port done_o, output, 1 bit: one-cycle pulse when a frame is complete.
REQ-018 The block SHALL have port error_o, output, 1 bit: sticky timeout flag.
REQ-019 The block SHALL have port byte_count_o, output, ADDR_W bits: bytes written in the current or last frame.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, REQ, POP, LATCH, WRITE and DONE, with all outputs registered.
REQ-021 In IDLE, when start_i=1 and abort_i=0, the block SHALL clear byte_count_o, error_o and the timeout counter, and go to REQ.
REQ-022 In IDLE with start_i=0, the block SHALL stay in IDLE; start_i SHALL be ignored in every other state.
REQ-023 In REQ with fifo_empty_i=0, the block SHALL go to POP and clear the timeout counter; with fifo_empty_i=1, it SHALL stay in REQ and increment the timeout counter.
REQ-024 fifo_rd_en_o SHALL be 1 only while in POP, for exactly one cycle per byte; POP SHALL go to LATCH unconditionally.
REQ-025 In LATCH, the block SHALL capture ram_data_o<=fifo_rdata_i and ram_addr_o<=byte_count_o, then go to WRITE.
REQ-026 ram_en_o and ram_we_o SHALL both be 1 only while in WRITE, for exactly one cycle per byte, with address and data stable.
REQ-027 In WRITE, the block SHALL increment byte_count_o; if the new count equals FRAME_LEN it SHALL go to DONE, otherwise to REQ.
REQ-028 The latency from fifo_empty_i falling (seen in REQ) to the RAM write cycle SHALL be 3 clocks (REQ->POP->LATCH->WRITE); minimum throughput SHALL be 1 byte per 4 clocks.
REQ-029 Addresses SHALL be 0..FRAME_LEN-1 strictly in order, with no wrap and no skipped or duplicate address.
REQ-030 In DONE, done_o SHALL be 1 for one cycle, after which the block SHALL go to IDLE with byte_count_o equal to FRAME_LEN and held.
REQ-031 Timeout: when the counter reaches TIMEOUT_CYC in REQ, the block SHALL set error_o=1 and go to IDLE, with no done_o and byte_count_o held.
REQ-032 abort_i=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done_o, no error_o and byte_count_o held.
REQ-033 If abort_i=1 in POP or LATCH, the popped byte SHALL be discarded and never written to RAM.
REQ-034 If abort_i=1 in WRITE, that write SHALL complete but the count SHALL not be incremented.
REQ-035 When abort_i and the timeout occur in the same cycle, abort SHALL win (error_o stays 0).
REQ-036 When abort_i and start_i are both 1 in IDLE, the block SHALL stay in IDLE.
REQ-037 With FRAME_LEN=1, the block SHALL perform one write to address 0, then DONE.
REQ-038 fifo_rdata_i SHALL be ignored outside LATCH.
REQ-039 A pop SHALL never be issued while fifo_empty_i=1.

Reset
REQ-040 While rst_i=1, asynchronously, the FSM SHALL be in IDLE, all outputs SHALL be 0 (including byte_count_o, ram_addr_o, ram_data_o and error_o), and the timeout counter SHALL be 0.
REQ-041 Reset asserted mid-frame SHALL abandon the frame, with no further FIFO pops or RAM writes after deassertion until start_i.

Verification
REQ-042 Nominal load: FRAME_LEN=4, FIFO preloaded with 0xA1,0xB2,0xC3,0xD4, start_i pulse -> RAM writes (0,A1)(1,B2)(2,C3)(3,D4), 4 pops, one done_o pulse, byte_count_o=4, busy_o low after DONE.
REQ-043 Starved FIFO: FRAME_LEN=4, bytes arrive 50 clocks apart with TIMEOUT_CYC=100 -> no error, writes exactly 3 clocks after each empty fall, done_o once.
REQ-044 Timeout: TIMEOUT_CYC=20, 2 of 4 bytes supplied -> error_o=1 on the 20th empty cycle, byte_count_o=2, no done_o, next start_i clears error_o.
REQ-045 Abort in LATCH: abort_i during byte 2 -> no write to address 1, IDLE next clock, byte_count_o=1, FIFO popped twice total.
REQ-046 Reset mid-frame: rst_i asserted during WRITE of byte 3 -> all outputs 0 immediately; after release with FIFO non-empty -> no pops until start_i.
REQ-047 Simultaneous events: abort_i in the timeout cycle -> error_o=0; start_i while busy -> ignored, addresses remain sequential.

Source files
------------

// File: rtl/uart_cerceve_yukleyici.sv
// ============================================================================
// Module : uart_cerceve_yukleyici
// Moves one frame of FRAME_LEN bytes from a UART RX FIFO into RAM, in address order.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_cerceve_yukleyici #(
  parameter int FRAME_LEN   = 76800,
  parameter int ADDR_W      = 17,
  parameter int TIMEOUT_CYC = 100_000_000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              fifo_empty_i,
  input  logic [7:0]        fifo_rdata_i,
  output logic              fifo_rd_en_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W-1:0] byte_count_o
);

  localparam int                TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    POP   = 3'd2,
    LATCH = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;

  // Outputs are registered: each strobe is set on the edge entering the state it belongs to.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      fifo_rd_en_o <= 1'b0;
      ram_en_o     <= 1'b0;
      ram_we_o     <= 1'b0;
      ram_addr_o   <= '0;
      ram_data_o   <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      byte_count_o <= '0;
    end else begin
      fifo_rd_en_o <= 1'b0;
      ram_en_o     <= 1'b0;
      ram_we_o     <= 1'b0;
      done_o       <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !abort_i) begin
            byte_count_o <= '0;
            error_o      <= 1'b0;
            tmo_cnt      <= '0;
            busy_o       <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          // Abort is checked first so it wins over a coincident timeout.
          if (abort_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else if (!fifo_empty_i) begin
            tmo_cnt      <= '0;
            fifo_rd_en_o <= 1'b1;
            state        <= POP;
          end else if (tmo_cnt == TMO_LAST) begin
            error_o <= 1'b1;
            busy_o  <= 1'b0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        POP: begin
          if (abort_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            state <= LATCH;
          end
        end
        LATCH: begin
          if (abort_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            ram_data_o <= fifo_rdata_i;
            ram_addr_o <= byte_count_o;
            ram_en_o   <= 1'b1;
            ram_we_o   <= 1'b1;
            state      <= WRITE;
          end
        end
        WRITE: begin
          // The write strobe is already on the bus; abort only suppresses the count.
          if (abort_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            byte_count_o <= byte_count_o + 1'b1;
            if (byte_count_o == LAST_IDX) begin
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              state <= REQ;
            end
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_cerceve_yukleyici.sv
// ============================================================================
// Module : tb_uart_cerceve_yukleyici
// Self-checking bench: FIFO model, write log and frame-level expectations.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_cerceve_yukleyici;

  localparam int FL  = 4;
  localparam int AW  = 8;
  localparam int TMO = 20;

  logic          clk_i = 1'b0;
  logic          rst_i, start_i, abort_i, fifo_empty_i;
  logic [7:0]    fifo_rdata_i;
  logic          fifo_rd_en_o, ram_en_o, ram_we_o, busy_o, done_o, error_o;
  logic [AW-1:0] ram_addr_o, byte_count_o;
  logic [7:0]    ram_data_o;

  uart_cerceve_yukleyici #(.FRAME_LEN(FL), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .fifo_empty_i(fifo_empty_i), .fifo_rdata_i(fifo_rdata_i),
    .fifo_rd_en_o(fifo_rd_en_o), .ram_en_o(ram_en_o), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o), .byte_count_o(byte_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int nsup;      // bytes the FIFO will ever supply
    int gap_lo;    // empty REQ cycles before each byte
    int gap_hi;
    bit noisy;     // toggle start_i while busy
    bit exp_err;
    int exp_cnt;
    bit exp_done;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cycnum = 0;
  int pops, dones;
  bit hold;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int w_addr[$];
  int w_data[$];
  int w_cyc[$];
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cycnum);
    end
  endtask

  // Advance one clock; observe this cycle's outputs at the falling edge.
  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
    cycnum++;
    if (fifo_rd_en_o) begin
      pops++;
      chk("pop_nonempty", fifo_q.size() > 0, 1);
      if (fifo_q.size() > 0) fifo_rdata_i = fifo_q.pop_front();
      hold = 1'b1;
    end else if (hold) begin
      hold = 1'b0;
    end else begin
      fifo_rdata_i = 8'($urandom);
    end
    if (ram_we_o) begin
      chk("we_with_en", ram_en_o, 1);
      w_addr.push_back(int'(ram_addr_o));
      w_data.push_back(int'(ram_data_o));
      w_cyc.push_back(cycnum);
    end
    if (done_o) dones++;
    fifo_empty_i = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    fifo_empty_i = 1'b0;
  endtask

  task automatic clear_logs();
    w_addr.delete(); w_data.delete(); w_cyc.delete(); exp_q.delete();
    pops = 0; dones = 0;
  endtask

  task automatic flush();
    fifo_q.delete();
    fifo_empty_i = 1'b1;
  endtask

  task automatic check_writes(input string tag, input int n);
    chk({tag, "_nwr"}, w_addr.size(), n);
    for (int i = 0; i < w_addr.size() && i < n; i++) begin
      chk({tag, "_addr"}, w_addr[i], i);
      chk({tag, "_data"}, w_data[i], exp_q[i]);
    end
  endtask

  // One frame with FIFO bytes arriving after a chosen number of empty REQ cycles.
  task automatic run_frame(input vec_t v);
    int gap, fall;
    bit timed_out;
    clear_logs();
    timed_out = 1'b0;
    start_i = 1'b1; cyc(); start_i = 1'b0;
    chk("start_busy", busy_o, 1);
    chk("start_err_clr", error_o, 0);
    chk("start_cnt_clr", byte_count_o, 0);
    for (int i = 0; i < FL; i++) begin
      if (i >= v.nsup) begin
        repeat (TMO - 1) begin
          if (v.noisy) start_i = 1'($urandom);
          cyc();
        end
        start_i = 1'b0;
        chk("tmo_not_early", error_o, 0);
        cyc();
        chk("tmo_err", error_o, 1);
        chk("tmo_busy", busy_o, 0);
        timed_out = 1'b1;
        break;
      end
      gap = $urandom_range(v.gap_hi, v.gap_lo);
      repeat (gap) begin
        if (v.noisy) start_i = 1'($urandom);
        cyc();
      end
      start_i = 1'b0;
      push(8'($urandom));
      fall = cycnum;
      repeat (3) cyc();
      chk("wr_latency3", ram_we_o, 1);
      chk("wr_at_cycle", (w_cyc.size() == i + 1) ? w_cyc[i] - fall : -1, 3);
      cyc();
    end
    if (!timed_out) begin
      chk("done_pulse", done_o, 1);
      cyc();
    end
    repeat (3) cyc();
    chk("end_busy", busy_o, 0);
    chk("end_err", error_o, v.exp_err);
    chk("end_cnt", byte_count_o, v.exp_cnt);
    chk("end_dones", dones, v.exp_done);
    chk("end_pops", pops, v.exp_cnt);
    check_writes("frame", v.exp_cnt);
    flush();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycnum);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int nsup;
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; fifo_empty_i = 1'b1;
    fifo_rdata_i = 8'h00; hold = 1'b0; pops = 0; dones = 0;

    vecs[0] = '{nsup: 4, gap_lo: 0,  gap_hi: 0,  noisy: 0, exp_err: 0, exp_cnt: 4, exp_done: 1};
    vecs[1] = '{nsup: 4, gap_lo: 19, gap_hi: 19, noisy: 0, exp_err: 0, exp_cnt: 4, exp_done: 1};
    vecs[2] = '{nsup: 4, gap_lo: 10, gap_hi: 19, noisy: 1, exp_err: 0, exp_cnt: 4, exp_done: 1};
    vecs[3] = '{nsup: 2, gap_lo: 0,  gap_hi: 5,  noisy: 0, exp_err: 1, exp_cnt: 2, exp_done: 0};
    vecs[4] = '{nsup: 0, gap_lo: 0,  gap_hi: 0,  noisy: 1, exp_err: 1, exp_cnt: 0, exp_done: 0};
    vecs[5] = '{nsup: 3, gap_lo: 1,  gap_hi: 8,  noisy: 1, exp_err: 1, exp_cnt: 3, exp_done: 0};

    @(negedge clk_i); @(negedge clk_i);
    chk("rst_outputs", {fifo_rd_en_o, ram_en_o, ram_we_o, busy_o, done_o, error_o}, 0);
    chk("rst_addr_data", {ram_addr_o, ram_data_o, byte_count_o}, 0);
    rst_i = 1'b0;
    repeat (2) cyc();

    // Prefilled FIFO: back-to-back writes every 4 clocks
    clear_logs();
    push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
    start_i = 1'b1; cyc(); start_i = 1'b0;
    repeat (17) cyc();
    check_writes("nominal", 4);
    for (int i = 1; i < w_cyc.size(); i++) chk("nominal_rate", w_cyc[i] - w_cyc[i-1], 4);
    chk("nominal_pops", pops, 4);
    chk("nominal_done", dones, 1);
    chk("nominal_cnt", byte_count_o, 4);
    chk("nominal_busy", busy_o, 0);
    flush();

    for (int k = 0; k < 6; k++) run_frame(vecs[k]);

    for (int k = 0; k < 12; k++) begin
      nsup = ($urandom_range(3, 0) == 0) ? $urandom_range(3, 0) : FL;
      v.nsup     = nsup;
      v.gap_lo   = 0;
      v.gap_hi   = $urandom_range(TMO - 1, 0);
      v.noisy    = 1'($urandom);
      v.exp_err  = (nsup < FL);
      v.exp_cnt  = (nsup < FL) ? nsup : FL;
      v.exp_done = (nsup >= FL);
      run_frame(v);
    end

    // Abort while the second byte is being latched
    clear_logs();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    start_i = 1'b1; cyc(); start_i = 1'b0;
    repeat (6) cyc();
    chk("abl_pops_before", pops, 2);
    abort_i = 1'b1; cyc(); abort_i = 1'b0;
    chk("abl_idle_next", busy_o, 0);
    repeat (6) cyc();
    chk("abl_cnt", byte_count_o, 1);
    chk("abl_pops", pops, 2);
    chk("abl_err", error_o, 0);
    chk("abl_done", dones, 0);
    check_writes("abl", 1);
    flush();

    // Abort during a write: the write lands, the count does not move
    clear_logs();
    push(8'h5A); push(8'h6B);
    start_i = 1'b1; cyc(); start_i = 1'b0;
    repeat (3) cyc();
    chk("abw_in_write", ram_we_o, 1);
    abort_i = 1'b1; cyc(); abort_i = 1'b0;
    chk("abw_idle", busy_o, 0);
    repeat (4) cyc();
    chk("abw_cnt", byte_count_o, 0);
    chk("abw_pops", pops, 1);
    check_writes("abw", 1);
    flush();

    // Abort in the very cycle the timeout would fire
    clear_logs();
    start_i = 1'b1; cyc(); start_i = 1'b0;
    repeat (TMO - 1) cyc();
    abort_i = 1'b1; cyc(); abort_i = 1'b0;
    chk("abt_err", error_o, 0);
    chk("abt_busy", busy_o, 0);

    // Start together with abort in IDLE does nothing
    start_i = 1'b1; abort_i = 1'b1; cyc(); start_i = 1'b0; abort_i = 1'b0;
    chk("sa_idle", busy_o, 0);

    // Reset during the third write, FIFO left non-empty afterwards
    clear_logs();
    push(8'h81); push(8'h92); push(8'hA3); push(8'hB4);
    start_i = 1'b1; cyc(); start_i = 1'b0;
    repeat (11) cyc();
    chk("rstm_in_write", {ram_we_o, ram_addr_o}, {1'b1, 8'd2});
    rst_i = 1'b1;
    #1;
    chk("rstm_outputs", {fifo_rd_en_o, ram_en_o, ram_we_o, busy_o, done_o, error_o}, 0);
    chk("rstm_addr_data", {ram_addr_o, ram_data_o, byte_count_o}, 0);
    repeat (2) cyc();
    rst_i = 1'b0;
    repeat (10) cyc();
    chk("rstm_no_pops", pops, 3);
    chk("rstm_busy", busy_o, 0);
    check_writes("rstm", 3);
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
